// File: rtl/ddr2_cmd_sched.sv
// DDR2 command scheduler: round-robin write/read arbitration, one burst per
// grant, driving the MIG address FIFO and the write-data beat strobe.
module ddr2_cmd_sched #(
   parameter int unsigned ADDR_WIDTH  = 31,
   parameter int unsigned WRITE_BURST = 8,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                  sys_clk,
   input  logic                  reset_n,
   input  logic                  phy_init_done,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   output logic                  wr_gnt,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_gnt,
   input  logic                  app_af_afull,
   input  logic                  app_wdf_afull,
   output logic [2:0]            af_cmd,
   output logic [ADDR_WIDTH-1:0] af_addr,
   output logic                  af_wren,
   output logic                  wdf_vd,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  wr_burst_cnt,
   output logic [CNT_WIDTH-1:0]  rd_burst_cnt
);

   localparam int unsigned BEATS     = WRITE_BURST / 2;
   localparam logic [2:0]  BeatsLast = 3'(BEATS);
   localparam logic [2:0]  CmdWrite  = 3'b000;
   localparam logic [2:0]  CmdRead   = 3'b001;

   if (!(WRITE_BURST == 4 || WRITE_BURST == 8)) begin : gen_bad_burst
      $error("ddr2_cmd_sched: WRITE_BURST must be 4 or 8");
   end

   typedef enum logic [1:0] {StIdle, StArb, StWr, StRd} state_e;

   state_e     state_q;
   logic [2:0] beat_q;     // beats already presented in the current write
   logic       last_wr_q;  // 1: last served was write, 0: read

   logic wr_ok;
   logic rd_ok;

   assign wr_ok = wr_req & ~app_af_afull & ~app_wdf_afull;
   assign rd_ok = rd_req & ~app_af_afull;

   // Scheduler FSM with registered command, beat and statistics outputs
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         beat_q       <= '0;
         last_wr_q    <= 1'b0;
         af_wren      <= 1'b0;
         af_cmd       <= '0;
         af_addr      <= '0;
         wr_gnt       <= 1'b0;
         rd_gnt       <= 1'b0;
         wdf_vd       <= 1'b0;
         busy         <= 1'b0;
         wr_burst_cnt <= '0;
         rd_burst_cnt <= '0;
      end else begin
         af_wren <= 1'b0;
         wr_gnt  <= 1'b0;
         rd_gnt  <= 1'b0;
         wdf_vd  <= 1'b0;
         busy    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (phy_init_done) state_q <= StArb;
            end
            StArb: begin
               if (!phy_init_done) begin
                  state_q <= StIdle;
               end else if (wr_ok && (!rd_ok || !last_wr_q)) begin
                  state_q      <= StWr;
                  af_wren      <= 1'b1;
                  af_cmd       <= CmdWrite;
                  af_addr      <= wr_addr;
                  wr_gnt       <= 1'b1;
                  wdf_vd       <= 1'b1;
                  busy         <= 1'b1;
                  beat_q       <= 3'd1;
                  last_wr_q    <= 1'b1;
                  wr_burst_cnt <= wr_burst_cnt + 1'b1;
               end else if (rd_ok) begin
                  state_q      <= StRd;
                  af_wren      <= 1'b1;
                  af_cmd       <= CmdRead;
                  af_addr      <= rd_addr;
                  rd_gnt       <= 1'b1;
                  busy         <= 1'b1;
                  last_wr_q    <= 1'b0;
                  rd_burst_cnt <= rd_burst_cnt + 1'b1;
               end
            end
            StWr: begin
               // Beats run back to back; app_wdf_afull is not consulted here
               if (beat_q == BeatsLast) begin
                  state_q <= StArb;
               end else begin
                  wdf_vd <= 1'b1;
                  busy   <= 1'b1;
                  beat_q <= beat_q + 3'd1;
               end
            end
            StRd: begin
               state_q <= StArb;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ddr2_cmd_sched.sv
// Bench for ddr2_cmd_sched: directed table, hand sequences and random stimulus
// against a schedule-based reference model, for BL8 and BL4 instances.
module tb_ddr2_cmd_sched;

   localparam int N = 8192;

   logic        sys_clk;
   logic        reset_n;
   logic        phy_init_done;
   logic        wr_req;
   logic        rd_req;
   logic        app_af_afull;
   logic        app_wdf_afull;
   logic [30:0] wr_addr;
   logic [30:0] rd_addr;

   logic        wr_gnt8, rd_gnt8, af_wren8, wdf_vd8, busy8;
   logic [2:0]  af_cmd8;
   logic [30:0] af_addr8;
   logic [15:0] wcnt8, rcnt8;
   logic        wr_gnt4, rd_gnt4, af_wren4, wdf_vd4, busy4;
   logic [2:0]  af_cmd4;
   logic [30:0] af_addr4;
   logic [15:0] wcnt4, rcnt4;

   ddr2_cmd_sched #(.ADDR_WIDTH(31), .WRITE_BURST(8), .CNT_WIDTH(16)) dut8 (
      .sys_clk(sys_clk), .reset_n(reset_n), .phy_init_done(phy_init_done),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_gnt(wr_gnt8),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt8),
      .app_af_afull(app_af_afull), .app_wdf_afull(app_wdf_afull),
      .af_cmd(af_cmd8), .af_addr(af_addr8), .af_wren(af_wren8),
      .wdf_vd(wdf_vd8), .busy(busy8), .wr_burst_cnt(wcnt8), .rd_burst_cnt(rcnt8)
   );

   ddr2_cmd_sched #(.ADDR_WIDTH(31), .WRITE_BURST(4), .CNT_WIDTH(16)) dut4 (
      .sys_clk(sys_clk), .reset_n(reset_n), .phy_init_done(phy_init_done),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_gnt(wr_gnt4),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt4),
      .app_af_afull(app_af_afull), .app_wdf_afull(app_wdf_afull),
      .af_cmd(af_cmd4), .af_addr(af_addr4), .af_wren(af_wren4),
      .wdf_vd(wdf_vd4), .busy(busy4), .wr_burst_cnt(wcnt4), .rd_burst_cnt(rcnt4)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model: expected outputs per cycle, filled ahead at each grant
   bit          e_wren [2][N];
   bit          e_wgnt [2][N];
   bit          e_rgnt [2][N];
   bit          e_vd   [2][N];
   bit          e_busy [2][N];
   logic [2:0]  e_cmd  [2][N];
   logic [30:0] e_addr [2][N];
   bit          m_up   [2];
   bit          m_lastw[2];
   int          m_free [2];
   logic [15:0] m_wc   [2];
   logic [15:0] m_rc   [2];

   task automatic mreset();
      for (int i = 0; i < 2; i++) begin
         for (int c = 0; c < N; c++) begin
            e_wren[i][c] = 0; e_wgnt[i][c] = 0; e_rgnt[i][c] = 0;
            e_vd[i][c] = 0; e_busy[i][c] = 0; e_cmd[i][c] = '0; e_addr[i][c] = '0;
         end
         m_up[i] = 0; m_lastw[i] = 0; m_free[i] = 0; m_wc[i] = '0; m_rc[i] = '0;
      end
   endtask

   // One clock edge t for instance i with b beats per write
   task automatic mstep(input int i, input int b, input int t);
      bit wok, rok, pw, pr;
      if (t + b + 1 >= N) return;
      e_cmd[i][t+1]  = e_cmd[i][t];
      e_addr[i][t+1] = e_addr[i][t];
      if (!m_up[i]) begin
         if (phy_init_done) begin
            m_up[i]   = 1;
            m_free[i] = t + 1;
         end
      end else if (t >= m_free[i]) begin
         if (!phy_init_done) begin
            m_up[i] = 0;
         end else begin
            wok = wr_req && !app_af_afull && !app_wdf_afull;
            rok = rd_req && !app_af_afull;
            pw  = wok && (!rok || !m_lastw[i]);
            pr  = rok && !pw;
            if (pw) begin
               e_wren[i][t+1] = 1; e_wgnt[i][t+1] = 1;
               e_cmd[i][t+1] = 3'b000; e_addr[i][t+1] = wr_addr;
               for (int k = 1; k <= b; k++) begin
                  e_vd[i][t+k] = 1; e_busy[i][t+k] = 1;
               end
               m_free[i] = t + b + 1; m_wc[i] = m_wc[i] + 16'd1; m_lastw[i] = 1;
            end else if (pr) begin
               e_wren[i][t+1] = 1; e_rgnt[i][t+1] = 1; e_busy[i][t+1] = 1;
               e_cmd[i][t+1] = 3'b001; e_addr[i][t+1] = rd_addr;
               m_free[i] = t + 2; m_rc[i] = m_rc[i] + 16'd1; m_lastw[i] = 0;
            end
         end
      end
   endtask

   function automatic logic [70:0] got_vec(input int i);
      if (i == 0)
         return {af_wren8, af_cmd8, af_addr8, wr_gnt8, rd_gnt8, wdf_vd8, busy8, wcnt8, rcnt8};
      return {af_wren4, af_cmd4, af_addr4, wr_gnt4, rd_gnt4, wdf_vd4, busy4, wcnt4, rcnt4};
   endfunction

   function automatic logic [70:0] exp_vec(input int i, input int c);
      return {e_wren[i][c], e_cmd[i][c], e_addr[i][c], e_wgnt[i][c], e_rgnt[i][c],
              e_vd[i][c], e_busy[i][c], m_wc[i], m_rc[i]};
   endfunction

   task automatic check(input string name, input logic [70:0] got, input logic [70:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask

   // Advance one edge, update the model, compare both instances
   task automatic step();
      int t;
      @(posedge sys_clk);
      t = cyc;
      cyc++;
      mstep(0, 4, t);
      mstep(1, 2, t);
      #1;
      check("model_bl8", got_vec(0), exp_vec(0, t + 1));
      check("model_bl4", got_vec(1), exp_vec(1, t + 1));
   endtask

   task automatic set_in(input logic [4:0] v);
      {phy_init_done, wr_req, rd_req, app_af_afull, app_wdf_afull} = v;
   endtask

   typedef struct packed {
      logic [4:0] in;   // phy, wr_req, rd_req, af_afull, wdf_afull
      logic [7:0] out;  // af_wren, af_cmd[2:0], wr_gnt, rd_gnt, wdf_vd, busy
   } vec_t;

   localparam logic [30:0] WA = 31'h100;
   localparam logic [30:0] RA = 31'h2A0;

   vec_t tbl[24];
   int   vd4_cnt;
   bit   found;

   initial begin
      tbl[0]  = '{5'b01000, 8'b0_000_0000};
      tbl[1]  = '{5'b01000, 8'b0_000_0000};
      tbl[2]  = '{5'b11000, 8'b0_000_0000};
      tbl[3]  = '{5'b11000, 8'b1_000_1011};
      tbl[4]  = '{5'b10000, 8'b0_000_0011};
      tbl[5]  = '{5'b10000, 8'b0_000_0011};
      tbl[6]  = '{5'b10000, 8'b0_000_0011};
      tbl[7]  = '{5'b10000, 8'b0_000_0000};
      tbl[8]  = '{5'b11100, 8'b1_001_0101};
      tbl[9]  = '{5'b11100, 8'b0_001_0000};
      tbl[10] = '{5'b11100, 8'b1_000_1011};
      tbl[11] = '{5'b11100, 8'b0_000_0011};
      tbl[12] = '{5'b11100, 8'b0_000_0011};
      tbl[13] = '{5'b11100, 8'b0_000_0011};
      tbl[14] = '{5'b11100, 8'b0_000_0000};
      tbl[15] = '{5'b11100, 8'b1_001_0101};
      tbl[16] = '{5'b11100, 8'b0_001_0000};
      tbl[17] = '{5'b11110, 8'b0_001_0000};
      tbl[18] = '{5'b11110, 8'b0_001_0000};
      tbl[19] = '{5'b11101, 8'b1_001_0101};
      tbl[20] = '{5'b11101, 8'b0_001_0000};
      tbl[21] = '{5'b11101, 8'b1_001_0101};
      tbl[22] = '{5'b11101, 8'b0_001_0000};
      tbl[23] = '{5'b11101, 8'b1_001_0101};

      reset_n = 1'b0;
      set_in(5'b00000);
      wr_addr = WA;
      rd_addr = RA;
      #1;
      check("reset_bl8", got_vec(0), 71'd0);
      check("reset_bl4", got_vec(1), 71'd0);
      repeat (2) begin @(posedge sys_clk); cyc++; end
      @(negedge sys_clk);
      reset_n = 1'b1;
      mreset();

      // Init gating, single write, alternation and afull blocking
      vd4_cnt = 0;
      for (int r = 0; r < 24; r++) begin
         set_in(tbl[r].in);
         step();
         check($sformatf("tbl%0d", r),
               {56'd0, af_wren8, af_cmd8, wr_gnt8, rd_gnt8, wdf_vd8, busy8},
               {56'd0, tbl[r].out});
         if (tbl[r].out[7])
            check($sformatf("tbl%0d_addr", r), {40'd0, af_addr8},
                  {40'd0, (tbl[r].out[4] ? RA : WA)});
         if (r >= 3 && r <= 7 && wdf_vd4) vd4_cnt++;
      end
      check("bl4_beats", {39'd0, 32'(vd4_cnt)}, 71'd2);
      check("counts_bl8", {39'd0, wcnt8, rcnt8}, {39'd0, 16'd2, 16'd5});

      // Reset in the middle of a BL8 write
      set_in(5'b11000);
      found = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (af_wren8) begin found = 1; break; end
      end
      check("wr_start_seen", {70'd0, found}, 71'd1);
      step();
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_bl8", got_vec(0), 71'd0);
      check("async_rst_bl4", got_vec(1), 71'd0);
      repeat (2) begin @(posedge sys_clk); cyc++; end
      #1;
      check("rst_hold_bl8", got_vec(0), 71'd0);
      @(negedge sys_clk);
      reset_n = 1'b1;
      mreset();
      set_in(5'b11100);
      step();
      step();
      check("post_rst_first_w", {69'd0, wr_gnt8, rd_gnt8}, 71'd2);

      // Random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         phy_init_done = ($urandom_range(0, 29) != 0);
         wr_req        = ($urandom_range(0, 3) != 0);
         rd_req        = ($urandom_range(0, 3) != 0);
         app_af_afull  = ($urandom_range(0, 7) == 0);
         app_wdf_afull = ($urandom_range(0, 5) == 0);
         wr_addr       = 31'($urandom);
         rd_addr       = 31'($urandom);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
